// File: rtl/bitsim_mac_pkg.sv
// bitsim_mac_pkg: FSM state type and width helpers shared by the
// bit-serial ("vertical") MAC unit and its column-term datapath.
package bitsim_mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } mac_state_e;

   // Select field: index within a group plus one "pick zero" bit.
   function automatic int sel_width(input int group_size);
      return $clog2(group_size) + 1;
   endfunction

   // Signed sum of one group of activations.
   function automatic int sum_width(input int group_size, input int data_width);
      return $clog2(group_size) + data_width;
   endfunction

   // One group term; sum_act - psum needs one bit more than a group sum.
   function automatic int term_width(input int group_size, input int data_width);
      return sum_width(group_size, data_width) + 1;
   endfunction

endpackage

// File: rtl/mac_vert_col_term.sv
// mac_vert_col_term: combinational term of one weight bit-column.
// Per group it sums the selected activations (or the complement
// difference), adds groups into T, negates T on the sign column, shifts it
// by the column index, and adds the sum_act * mul_const correction term.
module mac_vert_col_term
   import bitsim_mac_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_LENGTH = 16,
   parameter int GROUP_SIZE = 8,
   parameter int W_BITS     = 8,
   parameter int ACC_WIDTH  = 24
) (
   input  logic [VEC_LENGTH*DATA_WIDTH-1:0]                                      act,
   input  logic [(VEC_LENGTH/GROUP_SIZE)*sum_width(GROUP_SIZE, DATA_WIDTH)-1:0] sum_act,
   input  logic [(VEC_LENGTH/2)*sel_width(GROUP_SIZE)-1:0]                       act_sel,
   input  logic [VEC_LENGTH/GROUP_SIZE-1:0]                                      is_skip_zero,
   input  logic [2:0]                                                            mul_const,
   input  logic                                                                  is_shift_mul,
   input  logic [$clog2(W_BITS)-1:0]                                             col_cnt,
   output logic [ACC_WIDTH-1:0]                                                  term
);

   localparam int NG     = VEC_LENGTH / GROUP_SIZE;
   localparam int HALF   = GROUP_SIZE / 2;
   localparam int SEL_W  = sel_width(GROUP_SIZE);
   localparam int SUM_W  = sum_width(GROUP_SIZE, DATA_WIDTH);
   localparam int TERM_W = term_width(GROUP_SIZE, DATA_WIDTH);
   localparam int CNT_W  = $clog2(W_BITS);

   logic [SEL_W-1:0]            sel;
   logic signed [DATA_WIDTH-1:0] a_s;
   logic signed [SUM_W-1:0]     sa_s;
   logic signed [TERM_W-1:0]    psum;
   logic signed [TERM_W-1:0]    grp;
   logic signed [ACC_WIDTH-1:0] t_sum;
   logic signed [ACC_WIDTH-1:0] s_all;
   logic signed [ACC_WIDTH-1:0] m_term;

   // Build the column term; all wide arithmetic wraps at ACC_WIDTH.
   always_comb begin
      sel    = '0;
      a_s    = '0;
      sa_s   = '0;
      psum   = '0;
      grp    = '0;
      t_sum  = '0;
      s_all  = '0;
      m_term = '0;
      for (int g = 0; g < NG; g++) begin
         psum = '0;
         for (int k = 0; k < HALF; k++) begin
            sel = act_sel[(g*HALF + k)*SEL_W +: SEL_W];
            // Select values at or above GROUP_SIZE contribute zero.
            if (int'(sel) < GROUP_SIZE) begin
               a_s  = act[(g*GROUP_SIZE + int'(sel[SEL_W-2:0]))*DATA_WIDTH +: DATA_WIDTH];
               psum = psum + TERM_W'(a_s);
            end
         end
         sa_s  = sum_act[g*SUM_W +: SUM_W];
         grp   = is_skip_zero[g] ? psum : (TERM_W'(sa_s) - psum);
         t_sum = t_sum + ACC_WIDTH'(grp);
         s_all = s_all + ACC_WIDTH'(sa_s);
      end
      // The top weight column carries negative (two's complement) weight.
      if (col_cnt == CNT_W'(W_BITS-1)) begin
         t_sum = -t_sum;
      end
      t_sum  = t_sum << col_cnt;
      m_term = s_all * $signed({{(ACC_WIDTH-3){1'b0}}, mul_const});
      if (is_shift_mul) begin
         m_term = m_term <<< 3;
      end
      term = t_sum + m_term;
   end

endmodule

// File: rtl/mac_unit_vert_seq.sv
// mac_unit_vert_seq: bit-serial MAC. A job latches activations, then one
// column beat per weight bit adds its term through a 2-stage pipeline
// (term register, then accumulator). Optional build macro
// MAC_VERT_SEQ_SAT_EN clamps the non-pooled result instead of truncating.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready is 1 only in IDLE, col_ready only in RUN, out_valid
// only in DONE; valid on the other side is ignored while ready is 0, and the
// result stays stable while out_valid is 1 and out_ready is 0.
module mac_unit_vert_seq
   import bitsim_mac_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int VEC_LENGTH   = 16,
   parameter int GROUP_SIZE   = 8,
   parameter int W_BITS       = 8,
   parameter int ACC_WIDTH    = 24,
   parameter int RESULT_WIDTH = 16
) (
   input  logic                                                                  clk,
   input  logic                                                                  reset,
   input  logic                                                                  in_valid,
   output logic                                                                  in_ready,
   input  logic [VEC_LENGTH*DATA_WIDTH-1:0]                                      act,
   input  logic [(VEC_LENGTH/GROUP_SIZE)*sum_width(GROUP_SIZE, DATA_WIDTH)-1:0] sum_act,
   input  logic                                                                  load_accum,
   input  logic                                                                  is_pooling,
   input  logic [RESULT_WIDTH-1:0]                                               result_prev,
   input  logic                                                                  col_valid,
   output logic                                                                  col_ready,
   input  logic [(VEC_LENGTH/2)*sel_width(GROUP_SIZE)-1:0]                       act_sel,
   input  logic [VEC_LENGTH/GROUP_SIZE-1:0]                                      is_skip_zero,
   input  logic [2:0]                                                            mul_const,
   input  logic                                                                  is_shift_mul,
   output logic                                                                  out_valid,
   input  logic                                                                  out_ready,
   output logic [RESULT_WIDTH-1:0]                                               result
);

   localparam int NG    = VEC_LENGTH / GROUP_SIZE;
   localparam int SUM_W = sum_width(GROUP_SIZE, DATA_WIDTH);
   localparam int CNT_W = $clog2(W_BITS);

   mac_state_e                      state_q, state_d;
   logic [CNT_W-1:0]                col_cnt_q, col_cnt_d;
   logic                            drain_q, drain_d;
   logic signed [ACC_WIDTH-1:0]     term_q, term_d;
   logic signed [ACC_WIDTH-1:0]     accum_q, accum_d;
   logic [VEC_LENGTH*DATA_WIDTH-1:0] act_q, act_d;
   logic [NG*SUM_W-1:0]             sum_act_q, sum_act_d;
   logic                            pool_q, pool_d;
   logic signed [RESULT_WIDTH-1:0]  prev_q, prev_d;
   logic signed [RESULT_WIDTH-1:0]  result_q, result_d;
   logic                            in_ready_q, in_ready_d;
   logic                            col_ready_q, col_ready_d;
   logic                            out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0]            col_term;
   logic signed [RESULT_WIDTH-1:0]  res_base;

   mac_vert_col_term #(
      .DATA_WIDTH (DATA_WIDTH),
      .VEC_LENGTH (VEC_LENGTH),
      .GROUP_SIZE (GROUP_SIZE),
      .W_BITS     (W_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_col_term (
      .act          (act_q),
      .sum_act      (sum_act_q),
      .act_sel      (act_sel),
      .is_skip_zero (is_skip_zero),
      .mul_const    (mul_const),
      .is_shift_mul (is_shift_mul),
      .col_cnt      (col_cnt_q),
      .term         (col_term)
   );

`ifdef MAC_VERT_SEQ_SAT_EN
   localparam logic signed [RESULT_WIDTH-1:0] RES_MAX_R = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
   localparam logic signed [RESULT_WIDTH-1:0] RES_MIN_R = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0]    RES_MAX_A = ACC_WIDTH'(RES_MAX_R);
   localparam logic signed [ACC_WIDTH-1:0]    RES_MIN_A = ~RES_MAX_A;

   // Clamp the accumulator into the signed result range.
   always_comb begin
      if (accum_q > RES_MAX_A) begin
         res_base = RES_MAX_R;
      end else if (accum_q < RES_MIN_A) begin
         res_base = RES_MIN_R;
      end else begin
         res_base = accum_q[RESULT_WIDTH-1:0];
      end
   end
`else
   // Wrap the accumulator to the low result bits.
   always_comb begin
      res_base = accum_q[RESULT_WIDTH-1:0];
   end
`endif

   // Next-state, pipeline and accumulator logic.
   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      drain_d   = drain_q;
      term_d    = term_q;
      accum_d   = accum_q;
      act_d     = act_q;
      sum_act_d = sum_act_q;
      pool_d    = pool_q;
      prev_d    = prev_q;
      result_d  = result_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               act_d     = act;
               sum_act_d = sum_act;
               pool_d    = is_pooling;
               prev_d    = result_prev;
               accum_d   = load_accum ? ACC_WIDTH'($signed(result_prev)) : '0;
               term_d    = '0;
               col_cnt_d = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            // Pipeline only advances on a beat; a gap holds everything.
            if (col_valid) begin
               accum_d   = accum_q + term_q;
               term_d    = col_term;
               col_cnt_d = col_cnt_q + 1'b1;
               if (col_cnt_q == CNT_W'(W_BITS-1)) begin
                  col_cnt_d = '0;
                  drain_d   = 1'b0;
                  state_d   = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // First cycle flushes the last term, second captures the result.
            if (!drain_q) begin
               accum_d = accum_q + term_q;
               term_d  = '0;
               drain_d = 1'b1;
            end else begin
               result_d = (pool_q && (prev_q > res_base)) ? prev_q : res_base;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      col_ready_d = (state_d == ST_RUN);
      out_valid_d = (state_d == ST_DONE);
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         col_cnt_q   <= '0;
         drain_q     <= 1'b0;
         term_q      <= '0;
         accum_q     <= '0;
         act_q       <= '0;
         sum_act_q   <= '0;
         pool_q      <= 1'b0;
         prev_q      <= '0;
         result_q    <= '0;
         in_ready_q  <= 1'b1;
         col_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_cnt_q   <= col_cnt_d;
         drain_q     <= drain_d;
         term_q      <= term_d;
         accum_q     <= accum_d;
         act_q       <= act_d;
         sum_act_q   <= sum_act_d;
         pool_q      <= pool_d;
         prev_q      <= prev_d;
         result_q    <= result_d;
         in_ready_q  <= in_ready_d;
         col_ready_q <= col_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign col_ready = col_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// tb_mac_unit_vert_seq: directed vectors with hand-computed results for
// mac_unit_vert_seq at default parameters.
module tb_mac_unit_vert_seq;

   localparam int DW    = 8;
   localparam int VL    = 16;
   localparam int GS    = 8;
   localparam int WB    = 8;
   localparam int AW    = 24;
   localparam int RW    = 16;
   localparam int NG    = 2;
   localparam int SEL_W = 4;
   localparam int SUM_W = 11;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [VL*DW-1:0]      act;
   logic [NG*SUM_W-1:0]   sum_act;
   logic                  load_accum;
   logic                  is_pooling;
   logic [RW-1:0]         result_prev;
   logic                  col_valid;
   logic                  col_ready;
   logic [(VL/2)*SEL_W-1:0] act_sel;
   logic [NG-1:0]         is_skip_zero;
   logic [2:0]            mul_const;
   logic                  is_shift_mul;
   logic                  out_valid;
   logic                  out_ready;
   logic [RW-1:0]         result;

   int n_checks = 0;
   int n_errors = 0;

   // clock / reset
   always #5 clk = ~clk;

   mac_unit_vert_seq #(
      .DATA_WIDTH   (DW),
      .VEC_LENGTH   (VL),
      .GROUP_SIZE   (GS),
      .W_BITS       (WB),
      .ACC_WIDTH    (AW),
      .RESULT_WIDTH (RW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .act          (act),
      .sum_act      (sum_act),
      .load_accum   (load_accum),
      .is_pooling   (is_pooling),
      .result_prev  (result_prev),
      .col_valid    (col_valid),
      .col_ready    (col_ready),
      .act_sel      (act_sel),
      .is_skip_zero (is_skip_zero),
      .mul_const    (mul_const),
      .is_shift_mul (is_shift_mul),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic set_act_ones();
      for (int i = 0; i < VL; i++) act[i*DW +: DW] = 8'd1;
      sum_act[0 +: SUM_W]     = 11'd8;
      sum_act[SUM_W +: SUM_W] = 11'd8;
   endtask

   task automatic set_act_zero();
      act = '0;
      sum_act[0 +: SUM_W]     = 11'd8;
      sum_act[SUM_W +: SUM_W] = 11'd8;
   endtask

   // act[i] = i-8: group0 = -8..-1 (sum -36), group1 = 0..7 (sum 28)
   task automatic set_act_ramp();
      for (int i = 0; i < VL; i++) act[i*DW +: DW] = 8'(i - 8);
      sum_act[0 +: SUM_W]     = -11'sd36;
      sum_act[SUM_W +: SUM_W] = 11'sd28;
   endtask

   task automatic start_job(input string tag, input logic [RW-1:0] prev, input bit load, input bit pool);
      result_prev = prev;
      load_accum  = load;
      is_pooling  = pool;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      check_val({tag, "_run"}, 32'(col_ready), 32'd1);
   endtask

   // valid_sel: per group, select indices 0..3; otherwise every select is 15
   task automatic beat(input bit valid_sel, input logic [NG-1:0] skip, input logic [2:0] mc, input bit shm);
      for (int k = 0; k < VL/2; k++) act_sel[k*SEL_W +: SEL_W] = valid_sel ? 4'(k % 4) : 4'd15;
      is_skip_zero = skip;
      mul_const    = mc;
      is_shift_mul = shm;
      col_valid    = 1'b1;
      @(posedge clk); #1;
      col_valid    = 1'b0;
   endtask

   task automatic run_beats(input int n, input bit valid_sel, input logic [NG-1:0] skip,
                            input logic [2:0] mc, input bit shm);
      for (int i = 0; i < n; i++) beat(valid_sel, skip, mc, shm);
   endtask

   // Called right after the last beat; checks latency, result, hold, release.
   task automatic finish_job(input string tag, input logic [RW-1:0] exp, input int hold);
      logic [RW-1:0] exp_q[$];
      exp_q.push_back(exp);
      check_val({tag, "_ov_t0"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_val({tag, "_ov_t1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_val({tag, "_ov_t2"}, 32'(out_valid), 32'd1);
      check_val({tag, "_result"}, 32'(result), 32'(exp_q[0]));
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2 == 0);
         @(posedge clk); #1;
         check_val({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
         check_val({tag, "_hold_res"}, 32'(result), 32'(exp_q[0]));
         check_val({tag, "_hold_inr"}, 32'(in_ready), 32'd0);
      end
      // in_valid coinciding with the release must not start a job
      in_valid  = (hold > 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_val({tag, "_rel_inr"}, 32'(in_ready), 32'd1);
      check_val({tag, "_rel_colr"}, 32'(col_ready), 32'd0);
      check_val({tag, "_rel_ov"}, 32'(out_valid), 32'd0);
      void'(exp_q.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b0;
      in_valid     = 1'b0;
      act          = '0;
      sum_act      = '0;
      load_accum   = 1'b0;
      is_pooling   = 1'b0;
      result_prev  = '0;
      col_valid    = 1'b0;
      act_sel      = '0;
      is_skip_zero = '0;
      mul_const    = '0;
      is_shift_mul = 1'b0;
      out_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_col_ready", 32'(col_ready), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_result", 32'(result), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

      // reset mid-RUN after 3 beats abandons the job
      set_act_ones();
      start_job("abort", 16'd0, 1'b0, 1'b0);
      run_beats(3, 1'b1, 2'b11, 3'd0, 1'b0);
      reset = 1'b0;
      #1;
      check_val("abort_in_ready", 32'(in_ready), 32'd1);
      check_val("abort_col_ready", 32'(col_ready), 32'd0);
      check_val("abort_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("abort_idle", 32'(in_ready), 32'd1);
      check_val("abort_no_ov", 32'(out_valid), 32'd0);

      // all ones, 4 valid selects: T=8 per beat, -8 net
      start_job("ones", 16'd0, 1'b0, 1'b0);
      run_beats(8, 1'b1, 2'b11, 3'd0, 1'b0);
      finish_job("ones", 16'hFFF8, 0);

      // ramp: T=-4, M=-8 per beat -> -508-56+504 = -60
      set_act_ramp();
      start_job("ramp", 16'd0, 1'b0, 1'b0);
      run_beats(8, 1'b1, 2'b01, 3'd1, 1'b0);
      finish_job("ramp", 16'hFFC4, 0);

      // one beat of 16+384, a 4-cycle gap, then zero-valued beats
      set_act_zero();
      start_job("stall", 16'd0, 1'b0, 1'b0);
      beat(1'b0, 2'b00, 3'd3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_val("stall_gap_colr", 32'(col_ready), 32'd1);
         check_val("stall_gap_ov", 32'(out_valid), 32'd0);
      end
      run_beats(7, 1'b0, 2'b11, 3'd0, 1'b0);
      finish_job("stall", 16'd400, 0);

      // out_ready held low 5 cycles with in_valid pulses
      set_act_ones();
      start_job("hold", 16'd0, 1'b0, 1'b0);
      run_beats(8, 1'b1, 2'b11, 3'd0, 1'b0);
      finish_job("hold", 16'hFFF8, 5);

      // pooling: max(-8, 100) = 100, max(-8, -200) = -8
      start_job("pool_a", 16'd100, 1'b0, 1'b1);
      run_beats(8, 1'b1, 2'b11, 3'd0, 1'b0);
      finish_job("pool_a", 16'd100, 0);
      start_job("pool_b", 16'hFF38, 1'b0, 1'b1);
      run_beats(8, 1'b1, 2'b11, 3'd0, 1'b0);
      finish_job("pool_b", 16'hFFF8, 0);

      // load_accum from 32767, net +8
      start_job("load", 16'h7FFF, 1'b1, 1'b0);
      beat(1'b1, 2'b11, 3'd0, 1'b0);
      run_beats(7, 1'b0, 2'b11, 3'd0, 1'b0);
`ifdef MAC_VERT_SEQ_SAT_EN
      finish_job("load", 16'h7FFF, 0);
`else
      finish_job("load", 16'h8007, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
